control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  datapath clock, all state changes on rising edge.
REQ-002 SHALL have: clr  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: run  in  1  level enable; sequencing proceeds while high.
REQ-004 SHALL have: IR  in  32  instruction register contents from datapath.
REQ-005 SHALL have: PCout, MARin, IncPC, Zin, ZLOin, ZLOout, PCin, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath control strobes.
REQ-006 SHALL have: Rin  out  16  register load enables, bit n = Rn; Rout  out  16  register bus drives, bit n = Rn.
REQ-007 SHALL have: ALUSelection  out  5  ALU operation code.
REQ-008 SHALL have: done  out  1  one-cycle pulse at instruction completion; halted  out  1  high in HALT.
REQ-009 SHALL have: state  out  3  current state code (debug).

Function
REQ-010 SHALL use states IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, HALT=7; each T-state lasts exactly one clk cycle.
REQ-011 SHALL drive all outputs as Moore functions of the registered state and IR only, with no glitch-generating inputs other than IR.
REQ-012 SHALL decode IR: opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
REQ-013 SHALL classify opcode: 5'h00-5'h0D binary ALU; 5'h0E-5'h0F unary ALU (NOT/NEG); 5'h1F HALT; all others NOP.
REQ-014 IDLE: all outputs 0; next T0 if run=1, else IDLE.
REQ-015 T0: PCout=MARin=IncPC=Zin=ZLOin=1; next T1.
REQ-016 T1: ZLOout=PCin=Read=MDRin=1; next T2.
REQ-017 T2: MDRout=IRin=1; next, evaluated from the IR value after the T2 edge (i.e., in T3 decode path): see REQ-018.
REQ-018 The controller SHALL capture the class from Mdatain-loaded IR at the first cycle after T2: T3 entered unconditionally; in T3 if class=HALT next HALT with no strobes, if NOP next T0 (run=1) or IDLE (run=0) with no strobes.
REQ-019 T3 (ALU class): Rout[Rb]=1, Yin=1; next T4.
REQ-020 T4 binary: Rout[Rc]=1; unary: Rout[Rb]=1; both: ALUSelection=opcode, Zin=ZLOin=1; next T5.
REQ-021 T5: ZLOout=1, Rin[Ra]=1, done=1; next T0 if run=1, else IDLE.
REQ-022 ALUSelection SHALL be 5'b00000 in every state except T4.
REQ-023 Rin and Rout SHALL each be zero or one-hot; never both nonzero in one state.
REQ-024 At most one bus driver (PCout, ZLOout, MDRout, any Rout bit) SHALL be high in any state.
REQ-025 HALT: halted=1, all other outputs 0; exits only via clr.
REQ-026 run deasserted mid-instruction SHALL NOT abort; instruction completes, then IDLE.
REQ-027 Ra=0 SHALL be written like any other register (no R0 suppression).

Reset
REQ-028 clr=1 SHALL force state=IDLE asynchronously; all outputs 0 (halted=0, done=0, ALUSelection=0) without waiting for clk.
REQ-029 clr asserted mid-instruction SHALL abandon the instruction; no Rin bit asserted after clr rises.
REQ-030 After clr falls, first transition SHALL occur on the next rising clk with run sampled.

Verification
REQ-031 run=1, IR loaded 32'h28918000 (opcode 5'h05, Ra=1, Rb=2, Rc=3) -> T3 Rout=16'h0004 Yin; T4 Rout=16'h0008 ALUSelection=5'h05 Zin; T5 Rin=16'h0002 done; 7 cycles IDLE->T5.
REQ-032 IR=32'h7108_0000 (opcode 5'h0E, Ra=2, Rb=1) -> T4 Rout=16'h0002, ALUSelection=5'h0E; T5 Rin=16'h0004.
REQ-033 IR opcode 5'h1F -> after T3 state=7, halted=1, all strobes 0 for 10+ cycles; clr -> state=0, halted=0.
REQ-034 IR opcode 5'h12 (NOP), run=1 -> T0,T1,T2,T3 then T0; done never asserted, Rin never nonzero.
REQ-035 clr pulsed during T4 -> outputs 0 same timestep; state=0; Zin, Rout drop without clk edge.
REQ-036 run dropped during T1 -> sequence continues through T5 with done=1, then IDLE and holds.

Source files
------------

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired T-state controller for a single-bus datapath
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        ZLOin,
    output logic        ZLOout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  ALUSelection,
    output logic        done,
    output logic        halted,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [4:0] w_opcode;
    logic [3:0] w_ra;
    logic [3:0] w_rb;
    logic [3:0] w_rc;
    logic       w_is_binary;
    logic       w_is_unary;
    logic       w_is_alu;
    logic       w_is_halt;
    logic       w_unused_ir;

    assign w_opcode    = IR[31:27];
    assign w_ra        = IR[26:23];
    assign w_rb        = IR[22:19];
    assign w_rc        = IR[18:15];
    assign w_unused_ir = ^IR[14:0];

    assign w_is_binary = (w_opcode <= 5'h0D);
    assign w_is_unary  = (w_opcode == 5'h0E) || (w_opcode == 5'h0F);
    assign w_is_alu    = w_is_binary || w_is_unary;
    assign w_is_halt   = (w_opcode == 5'h1F);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = run ? S_T0 : S_IDLE;
            S_T0:   w_next = S_T1;
            S_T1:   w_next = S_T2;
            S_T2:   w_next = S_T3;
            // IR has been loaded by the T2 edge, so the class is decoded here
            S_T3: begin
                if (w_is_halt) begin
                    w_next = S_HALT;
                end else if (w_is_alu) begin
                    w_next = S_T4;
                end else begin
                    w_next = run ? S_T0 : S_IDLE;
                end
            end
            S_T4:   w_next = S_T5;
            S_T5:   w_next = run ? S_T0 : S_IDLE;
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        PCout        = 1'b0;
        MARin        = 1'b0;
        IncPC        = 1'b0;
        Zin          = 1'b0;
        ZLOin        = 1'b0;
        ZLOout       = 1'b0;
        PCin         = 1'b0;
        Read         = 1'b0;
        MDRin        = 1'b0;
        MDRout       = 1'b0;
        IRin         = 1'b0;
        Yin          = 1'b0;
        Rin          = 16'h0000;
        Rout         = 16'h0000;
        ALUSelection = 5'b00000;
        done         = 1'b0;
        halted       = 1'b0;
        state        = r_state;
        case (r_state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
                ZLOin = 1'b1;
            end
            S_T1: begin
                ZLOout = 1'b1;
                PCin   = 1'b1;
                Read   = 1'b1;
                MDRin  = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (w_is_alu) begin
                    Rout = 16'h0001 << w_rb;
                    Yin  = 1'b1;
                end
            end
            // Unary ops take their operand from Rb again; Y holds a don't-care copy
            S_T4: begin
                Rout         = 16'h0001 << (w_is_binary ? w_rc : w_rb);
                ALUSelection = w_opcode;
                Zin          = 1'b1;
                ZLOin        = 1'b1;
            end
            S_T5: begin
                ZLOout = 1'b1;
                Rin    = 16'h0001 << w_ra;
                done   = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized bench for control_sequencer against an instruction-step model
module tb_control_sequencer;

    logic        clk;
    logic        clr;
    logic        run;
    logic [31:0] IR;
    logic        PCout, MARin, IncPC, Zin, ZLOin, ZLOout, PCin, Read;
    logic        MDRin, MDRout, IRin, Yin;
    logic [15:0] Rin, Rout;
    logic [4:0]  ALUSelection;
    logic        done, halted;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;
    int m_step = -1;

    control_sequencer dut (
        .clk(clk), .clr(clr), .run(run), .IR(IR),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .ZLOin(ZLOin),
        .ZLOout(ZLOout), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Yin(Yin), .Rin(Rin), .Rout(Rout), .ALUSelection(ALUSelection),
        .done(done), .halted(halted), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [53:0] dut_vec();
        return {PCout, MARin, IncPC, Zin, ZLOin, ZLOout, PCin, Read, MDRin, MDRout,
                IRin, Yin, Rin, Rout, ALUSelection, done, halted, state};
    endfunction

    // step: -1 idle, 0..5 for T0..T5, 7 halted
    function automatic logic [53:0] exp_vec(int step, logic [31:0] ir);
        logic [11:0] s;
        logic [15:0] rin, rout;
        logic [4:0]  op, alu;
        logic        dn, hl, bin, alu_cls;
        logic [2:0]  st;
        op = ir[31:27];
        bin = (op <= 5'h0D);
        alu_cls = bin || (op == 5'h0E) || (op == 5'h0F);
        s = '0; rin = '0; rout = '0; alu = '0; dn = 1'b0; hl = 1'b0; st = 3'd0;
        case (step)
            0: begin s = 12'b1111_1000_0000; st = 3'd1; end
            1: begin s = 12'b0000_0111_1000; st = 3'd2; end
            2: begin s = 12'b0000_0000_0110; st = 3'd3; end
            3: begin
                st = 3'd4;
                if (alu_cls) begin
                    rout = 16'h0001 << ir[22:19];
                    s[0] = 1'b1;
                end
            end
            4: begin
                st = 3'd5;
                rout = 16'h0001 << (bin ? ir[18:15] : ir[22:19]);
                alu = op;
                s[8] = 1'b1;
                s[7] = 1'b1;
            end
            5: begin
                st = 3'd6;
                s[6] = 1'b1;
                rin = 16'h0001 << ir[26:23];
                dn = 1'b1;
            end
            7: begin st = 3'd7; hl = 1'b1; end
            default: ;
        endcase
        return {s, rin, rout, alu, dn, hl, st};
    endfunction

    function automatic int instr_len(logic [31:0] ir);
        logic [4:0] op;
        op = ir[31:27];
        if (op <= 5'h0F) return 6;
        return 4;
    endfunction

    // Advance one clock and the model; inputs change only at negedge
    task automatic tick();
        @(posedge clk);
        if (m_step == -1) m_step = run ? 0 : -1;
        else if (m_step == 7) m_step = 7;
        else if (m_step == 3 && IR[31:27] == 5'h1F) m_step = 7;
        else if (m_step == instr_len(IR) - 1) m_step = run ? 0 : -1;
        else m_step = m_step + 1;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        #1;
        clr = 1'b0;
        m_step = -1;
    endtask

    function automatic logic [31:0] rand_ir(int kind);
        logic [4:0] op;
        case (kind)
            0: op = 5'($urandom_range(0, 13));
            1: op = 5'($urandom_range(14, 15));
            2: op = 5'($urandom_range(16, 30));
            default: op = 5'h1F;
        endcase
        return {op, 27'($urandom)};
    endfunction

    task automatic test_reset();
        clr = 1'b1; run = 1'b0; IR = 32'h0;
        @(negedge clk);
        total++;
        if (dut_vec() !== exp_vec(-1, IR)) begin
            bad++; $display("FAIL reset_outputs: got %h want %h", dut_vec(), exp_vec(-1, IR));
        end
        clr = 1'b0; m_step = -1;
        tick();
        total++;
        if (state !== 3'd0) begin
            bad++; $display("FAIL reset_idle_hold: got state %0d want 0", state);
        end
    endtask

    task automatic test_binary();
        IR = 32'h28918000; run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (dut_vec() !== exp_vec(m_step, IR)) begin
                bad++; $display("FAIL binary_step%0d: got %h want %h", i, dut_vec(), exp_vec(m_step, IR));
            end
            if (i == 3) begin
                total++;
                if (Rout !== 16'h0004 || Yin !== 1'b1) begin
                    bad++; $display("FAIL binary_t3: got Rout %h Yin %b want 0004 1", Rout, Yin);
                end
            end
            if (i == 4) begin
                total++;
                if (Rout !== 16'h0008 || ALUSelection !== 5'h05 || Zin !== 1'b1) begin
                    bad++; $display("FAIL binary_t4: got Rout %h ALU %h Zin %b want 0008 05 1", Rout, ALUSelection, Zin);
                end
            end
        end
        total++;
        if (state !== 3'd6 || Rin !== 16'h0002 || done !== 1'b1) begin
            bad++; $display("FAIL binary_t5: got state %0d Rin %h done %b want 6 0002 1", state, Rin, done);
        end
        run = 1'b0;
        tick();
        total++;
        if (state !== 3'd0) begin
            bad++; $display("FAIL binary_end_idle: got state %0d want 0", state);
        end
    endtask

    task automatic test_unary();
        IR = 32'h7108_0000; run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (dut_vec() !== exp_vec(m_step, IR)) begin
                bad++; $display("FAIL unary_step%0d: got %h want %h", i, dut_vec(), exp_vec(m_step, IR));
            end
            if (i == 4) begin
                total++;
                if (Rout !== 16'h0002 || ALUSelection !== 5'h0E) begin
                    bad++; $display("FAIL unary_t4: got Rout %h ALU %h want 0002 0e", Rout, ALUSelection);
                end
            end
            if (i == 5) begin
                total++;
                if (Rin !== 16'h0004) begin
                    bad++; $display("FAIL unary_t5: got Rin %h want 0004", Rin);
                end
            end
        end
        run = 1'b0;
        tick();
    endtask

    task automatic test_nop();
        logic [31:0] v;
        v = rand_ir(2);
        v[31:27] = 5'h12;
        IR = v; run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (done !== 1'b0 || Rin !== 16'h0000 || state !== 3'(((i % 4) + 1))) begin
                bad++; $display("FAIL nop_step%0d: got state %0d done %b Rin %h want state %0d done 0 Rin 0000",
                                i, state, done, Rin, (i % 4) + 1);
            end
        end
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (dut_vec() !== exp_vec(m_step, IR)) begin
                bad++; $display("FAIL nop_drain%0d: got %h want %h", i, dut_vec(), exp_vec(m_step, IR));
            end
        end
    endtask

    task automatic test_halt();
        IR = rand_ir(3); run = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (dut_vec() !== exp_vec(7, IR)) begin
                bad++; $display("FAIL halt_hold%0d: got %h want %h", i, dut_vec(), exp_vec(7, IR));
            end
        end
        run = 1'b0;
        clr = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || halted !== 1'b0) begin
            bad++; $display("FAIL halt_clr: got state %0d halted %b want 0 0", state, halted);
        end
        clr = 1'b0; m_step = -1;
        @(negedge clk);
    endtask

    task automatic test_clr_mid();
        IR = rand_ir(0); run = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (state !== 3'd5 || Zin !== 1'b1) begin
            bad++; $display("FAIL clr_pre_t4: got state %0d Zin %b want 5 1", state, Zin);
        end
        clr = 1'b1;
        #1;
        total++;
        if (dut_vec() !== exp_vec(-1, IR) || Zin !== 1'b0 || Rout !== 16'h0) begin
            bad++; $display("FAIL clr_async: got %h want %h", dut_vec(), exp_vec(-1, IR));
        end
        #1;
        clr = 1'b0; m_step = -1;
        tick();
        total++;
        if (state !== 3'd1 || Rin !== 16'h0) begin
            bad++; $display("FAIL clr_restart: got state %0d Rin %h want 1 0000", state, Rin);
        end
        run = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (state !== 3'd0) begin
            bad++; $display("FAIL clr_restart_idle: got state %0d want 0", state);
        end
    endtask

    task automatic test_run_drop();
        int seen_done;
        seen_done = 0;
        IR = rand_ir(0); run = 1'b1;
        tick();
        tick();
        run = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) seen_done++;
            total++;
            if (dut_vec() !== exp_vec(m_step, IR)) begin
                bad++; $display("FAIL rundrop_step%0d: got %h want %h", i, dut_vec(), exp_vec(m_step, IR));
            end
        end
        total++;
        if (seen_done != 1 || state !== 3'd0) begin
            bad++; $display("FAIL rundrop_done: got done_count %0d state %0d want 1 0", seen_done, state);
        end
    endtask

    task automatic test_random();
        int drivers;
        for (int c = 0; c < 400; c++) begin
            if (m_step == -1 || m_step == 0 || m_step == 1) begin
                int r;
                r = $urandom_range(0, 19);
                IR = rand_ir(r < 9 ? 0 : (r < 13 ? 1 : (r < 19 ? 2 : 3)));
            end
            run = ($urandom_range(0, 3) != 0);
            if (m_step == 7 || $urandom_range(0, 59) == 0) pulse_clr();
            tick();
            total++;
            if (dut_vec() !== exp_vec(m_step, IR)) begin
                bad++; $display("FAIL random_cycle%0d: got %h want %h ir %h", c, dut_vec(), exp_vec(m_step, IR), IR);
            end
            drivers = int'(PCout) + int'(ZLOout) + int'(MDRout) + $countones(Rout);
            total++;
            if (drivers > 1 || $countones(Rin) > 1 || (Rin != 0 && Rout != 0)) begin
                bad++; $display("FAIL random_bus%0d: got drivers %0d Rin %h Rout %h want <=1 one-hot exclusive",
                                c, drivers, Rin, Rout);
            end
        end
    endtask

    initial begin
        clr = 1'b1; run = 1'b0; IR = 32'h0;
        test_reset();
        test_binary();
        test_unary();
        test_nop();
        test_halt();
        test_clr_mid();
        test_run_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
